// File: rtl/lsu_mem_master.sv
// Load/store initiator: converts byte/halfword/word CPU requests into
// word-wide memory transactions. Sub-word stores use read-modify-write.
// Loads are sign- or zero-extended. Bad alignment, out-of-range
// addresses and illegal sizes are reported through cpu_err.
`timescale 1ns/1ps
module lsu_mem_master #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0]        SZ_BYTE    = 2'b00;
    localparam logic [1:0]        SZ_HALF    = 2'b01;
    localparam logic [1:0]        SZ_WORD    = 2'b10;
    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    state_e              state_q,  state_d;
    logic                we_q,     we_d;
    logic [1:0]          size_q,   size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic                err_q,    err_d;
    logic [31:0]         rbuf_q,   rbuf_d;
    logic [31:0]         rdata_q,  rdata_d;

    logic                req_err;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    // Classify the incoming request: illegal size, misalignment, or beyond memory.
    always_comb begin
        req_err = 1'b0;
        if (cpu_size == 2'b11)
            req_err = 1'b1;
        else if (cpu_size == SZ_HALF && cpu_addr[0])
            req_err = 1'b1;
        else if (cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (cpu_addr[ADDR_W-1:2] >= WORD_LIMIT)
            req_err = 1'b1;
    end

    // Extract the addressed lane from the memory word and extend it to 32 bits.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
            SZ_HALF: load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_rd;
        endcase
    end

    // Merge store data into the buffered word, replacing only the addressed lanes.
    always_comb begin
        merged = rbuf_q;
        case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Next-state logic: accept in IDLE, read the word, optionally write it back, respond.
    always_comb begin
        // NOTE: every *_d defaults to its current value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    size_d   = cpu_size;
                    signed_d = cpu_signed;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    err_d    = req_err;
                    state_d  = req_err ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                rbuf_d = mem_rd;
                if (!we_q)
                    rdata_d = load_ext;
                state_d = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_ready = (state_q == S_IDLE);
    assign cpu_done  = (state_q == S_RESP);
    assign cpu_err   = (state_q == S_RESP) && err_q;
    assign cpu_rdata = rdata_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_we    = (state_q == S_WRITE);
    assign mem_wd    = merged;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the datapath and the word-wide data memory.
- The data memory has a combinational read, a synchronous write on WE, and word index Addr[7:2].
- This block turns byte, halfword and word load/store requests into word-level memory transactions. Sub-word stores are done as read-modify-write.
- It provides sign/zero extension for loads and alignment/range error detection, under a simple req/ready/done handshake.

Parameters:
- ADDR_W, 32, width of CPU and memory addresses.
- MEM_WORDS, 64, number of words in the data memory; word indices >= MEM_WORDS are errors.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  request valid; accepted when cpu_req && cpu_ready.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- cpu_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- cpu_addr  input  ADDR_W  byte address.
- cpu_wdata  input  32  store data; byte/half taken from the low bits.
- cpu_ready  output  1  high only in IDLE.
- cpu_done  output  1  one-cycle completion pulse.
- cpu_err  output  1  valid with cpu_done; 1 = misaligned, out of range, or illegal size.
- cpu_rdata  output  32  load result; valid with cpu_done and held until the next load completes.
- mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_we  output  1  memory write enable.
- mem_wd  output  32  memory write data.
- mem_rd  input  32  memory combinational read data.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - cpu_done=0, cpu_err=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wd=0.
  - All latched request fields go to 0.
- Accept: in IDLE with cpu_req=1, latch we, size, signed, addr and wdata. Inputs are ignored in every other state.
- Error check at accept. An error is any of:
  - size=11;
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0;
  - addr[ADDR_W-1:2] >= MEM_WORDS.
  - On error go to RESP with err=1. No memory access is made and mem_we is never asserted.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> READ on an accepted request without error; IDLE -> RESP on an error.
  - READ: mem_addr = word address, mem_we=0; mem_rd is captured into rbuf at the edge. Load -> RESP; store -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle; mem_wd = rbuf merged with the store data in the addressed lanes. -> RESP.
  - RESP: cpu_done=1 for one cycle and cpu_err is valid. A load updates cpu_rdata; an error or a store leaves it unchanged. -> IDLE.
- Latency from the accept edge to cpu_done high:
  - load: 2 cycles;
  - store: 3 cycles;
  - error: 1 cycle.
- Back-to-back: the next request can be accepted in the cycle after RESP, when IDLE and cpu_ready=1.
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Loads extract the addressed lane, then sign- or zero-extend to 32 bits. Word loads ignore cpu_signed.
- Store merge: only the addressed lanes are replaced, and all other bits equal rbuf. A word store replaces all 32 bits.
- mem_we is asserted only in WRITE. mem_addr is held stable through READ and WRITE.
- Reset mid-operation: the transaction is abandoned with no cpu_done. If rst rises during WRITE before the clock edge, mem_we drops at once and no write happens.

Test Plan:
- Store word 0x11223344 @0x10, then load byte signed @0x13 -> cpu_rdata=0x00000011, err=0, done exactly 2 cycles after accept.
- Store byte 0x80 @0x12 -> mem_wd=0x11803344. Then:
  - load byte signed @0x12 -> 0xFFFFFF80;
  - load byte unsigned -> 0x00000080;
  - load word @0x10 -> 0x11803344.
- Store half 0xBEEF @0x16 over a zero word @0x14 -> word @0x14 = 0xBEEF0000; load half signed @0x16 -> 0xFFFFBEEF.
- Error cases, each -> cpu_err=1 one cycle after accept, mem_we never high, memory unchanged:
  - load half @0x11;
  - store word @0x22;
  - size=11;
  - store word @0x100 with MEM_WORDS=64.
- Hold cpu_req=1 with changing cpu_addr during READ/WRITE -> ignored, cpu_ready=0. A new request is accepted only in IDLE.
- Assert rst during WRITE of store 0xDEADBEEF @0x04 -> mem_we drops immediately, word @0x04 unchanged, no cpu_done, cpu_ready=1 after reset.
